// File: rtl/alu_hilo_exec_if.sv
// EX-stage bundle between the pipeline and the ALU/HI-LO unit.
// The master drives the operation; the slave returns results and stall.
interface alu_hilo_exec_if;
    logic [4:0]  alucontrol;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sa;
    logic        valid_i;
    logic        flush;
    logic [31:0] result;
    logic        overflow;
    logic        stall_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output alucontrol, a, b, sa, valid_i, flush,
        input  result, overflow, stall_o, hi_o, lo_o
    );

    modport slave (
        input  alucontrol, a, b, sa, valid_i, flush,
        output result, overflow, stall_o, hi_o, lo_o
    );
endinterface

// File: rtl/alu_hilo_exec.sv
// EX-stage ALU with HI/LO pair, one-cycle multiply and iterative divide.
// Control codes match the ALU decoder's *_CONTROL encoding.
package alu_hilo_pkg;
    localparam logic [4:0] AND_CONTROL   = 5'b00000;
    localparam logic [4:0] OR_CONTROL    = 5'b00001;
    localparam logic [4:0] ADD_CONTROL   = 5'b00010;
    localparam logic [4:0] LUI_CONTROL   = 5'b00011;
    localparam logic [4:0] XOR_CONTROL   = 5'b00100;
    localparam logic [4:0] NOR_CONTROL   = 5'b00101;
    localparam logic [4:0] SUB_CONTROL   = 5'b00110;
    localparam logic [4:0] SLT_CONTROL   = 5'b00111;
    localparam logic [4:0] SLL_CONTROL   = 5'b01000;
    localparam logic [4:0] SRL_CONTROL   = 5'b01001;
    localparam logic [4:0] SRA_CONTROL   = 5'b01010;
    localparam logic [4:0] SLLV_CONTROL  = 5'b01011;
    localparam logic [4:0] SRLV_CONTROL  = 5'b01100;
    localparam logic [4:0] SRAV_CONTROL  = 5'b01101;
    localparam logic [4:0] ADDU_CONTROL  = 5'b10000;
    localparam logic [4:0] SUBU_CONTROL  = 5'b10001;
    localparam logic [4:0] SLTU_CONTROL  = 5'b10010;
    localparam logic [4:0] MFHI_CONTROL  = 5'b10011;
    localparam logic [4:0] MFLO_CONTROL  = 5'b10100;
    localparam logic [4:0] MTHI_CONTROL  = 5'b10101;
    localparam logic [4:0] MTLO_CONTROL  = 5'b10110;
    localparam logic [4:0] MULT_CONTROL  = 5'b10111;
    localparam logic [4:0] MULTU_CONTROL = 5'b11000;
    localparam logic [4:0] DIV_CONTROL   = 5'b11001;
    localparam logic [4:0] DIVU_CONTROL  = 5'b11010;
endpackage

module alu_hilo_exec #(
    parameter int RADIX_BITS = 1
) (
    input logic clk,
    input logic rst,
    alu_hilo_exec_if.slave bus
);
    import alu_hilo_pkg::*;

    localparam int N = 32 / RADIX_BITS;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic        neg_q;
    logic        neg_r;
    logic        dzero;
    logic [5:0]  k;

    logic        go;
    logic        is_div;
    logic        is_sdiv;
    logic        start;
    logic        last;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;
    logic [31:0] rem_fix;
    logic [31:0] quo_fix;

    // BUSY blocks all writes; DONE lets the next instruction through
    assign go      = bus.valid_i & ~bus.flush & (state != BUSY);
    assign is_sdiv = (bus.alucontrol == DIV_CONTROL);
    assign is_div  = is_sdiv | (bus.alucontrol == DIVU_CONTROL);
    assign start   = go & is_div & (state == IDLE);
    assign last    = (k == 6'(N - 1));

    assign sum  = bus.a + bus.b;
    assign diff = bus.a - bus.b;

    assign prod_s = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
    assign prod_u = {32'b0, bus.a} * {32'b0, bus.b};

    assign bus.hi_o = hi;
    assign bus.lo_o = lo;

    always_comb begin
        state_nxt   = state;
        bus.stall_o = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = BUSY;
                    bus.stall_o = 1'b1;
                end
            end
            BUSY: begin
                bus.stall_o = 1'b1;
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Restoring divide: RADIX_BITS shift/subtract steps per cycle
    always_comb begin
        logic [31:0] r;
        logic [31:0] q;
        logic [32:0] t;
        r = rem;
        q = quo;
        t = '0;
        for (int i = 0; i < RADIX_BITS; i++) begin
            t = {r, q[31]};
            if (t >= {1'b0, dvs}) begin
                t = t - {1'b0, dvs};
                q = {q[30:0], 1'b1};
            end else begin
                q = {q[30:0], 1'b0};
            end
            r = t[31:0];
        end
        rem_nxt = r;
        quo_nxt = q;
    end

    assign rem_fix = neg_r ? (32'd0 - rem_nxt) : rem_nxt;
    assign quo_fix = dzero ? 32'hFFFF_FFFF
                   : (neg_q ? (32'd0 - quo_nxt) : quo_nxt);

    always_comb begin
        bus.result   = 32'd0;
        bus.overflow = 1'b0;
        case (bus.alucontrol)
            AND_CONTROL:  bus.result = bus.a & bus.b;
            OR_CONTROL:   bus.result = bus.a | bus.b;
            XOR_CONTROL:  bus.result = bus.a ^ bus.b;
            NOR_CONTROL:  bus.result = ~(bus.a | bus.b);
            LUI_CONTROL:  bus.result = {bus.b[15:0], 16'h0000};
            SLT_CONTROL:  bus.result = {31'd0, $signed(bus.a) < $signed(bus.b)};
            SLTU_CONTROL: bus.result = {31'd0, bus.a < bus.b};
            ADD_CONTROL: begin
                bus.result   = sum;
                bus.overflow = (bus.a[31] == bus.b[31]) & (sum[31] != bus.a[31]);
            end
            ADDU_CONTROL: bus.result = sum;
            SUB_CONTROL: begin
                bus.result   = diff;
                bus.overflow = (bus.a[31] != bus.b[31]) & (diff[31] != bus.a[31]);
            end
            SUBU_CONTROL: bus.result = diff;
            SLL_CONTROL:  bus.result = bus.b << bus.sa;
            SRL_CONTROL:  bus.result = bus.b >> bus.sa;
            SRA_CONTROL:  bus.result = $unsigned($signed(bus.b) >>> bus.sa);
            SLLV_CONTROL: bus.result = bus.b << bus.a[4:0];
            SRLV_CONTROL: bus.result = bus.b >> bus.a[4:0];
            SRAV_CONTROL: bus.result = $unsigned($signed(bus.b) >>> bus.a[4:0]);
            MFHI_CONTROL: bus.result = hi;
            MFLO_CONTROL: bus.result = lo;
            default:      bus.result = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hi    <= 32'd0;
            lo    <= 32'd0;
            rem   <= 32'd0;
            quo   <= 32'd0;
            dvs   <= 32'd0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dzero <= 1'b0;
            k     <= 6'd0;
        end else begin
            state <= state_nxt;
            if (start) begin
                rem   <= 32'd0;
                quo   <= (is_sdiv & bus.a[31]) ? (32'd0 - bus.a) : bus.a;
                dvs   <= (is_sdiv & bus.b[31]) ? (32'd0 - bus.b) : bus.b;
                neg_q <= is_sdiv & (bus.a[31] ^ bus.b[31]);
                neg_r <= is_sdiv & bus.a[31];
                dzero <= (bus.b == 32'd0);
                k     <= 6'd0;
            end else if (state == BUSY) begin
                if (!bus.flush) begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    k   <= k + 6'd1;
                    if (last) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
            end else if (go) begin
                case (bus.alucontrol)
                    MTHI_CONTROL:  hi <= bus.a;
                    MTLO_CONTROL:  lo <= bus.a;
                    MULT_CONTROL:  {hi, lo} <= prod_s;
                    MULTU_CONTROL: {hi, lo} <= prod_u;
                    default: ;
                endcase
            end
        end
    end
endmodule
